rst_sequencer: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/rst_sequencer.sv | 119 +++++++++++
 tb/tb_rst_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared state encodings and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    CORE_RST  = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam int unsigned RETRY_W = 4;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rst_sequencer.sv
// PLL bring-up and core reset sequencer: lock qualification with timeout/retry,
// stability window, core reset stretch, run-time lock loss and software reset.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT    = 65536,
  parameter int unsigned STABLE_CYCLES   = 256,
  parameter int unsigned CORE_RST_CYCLES = 16,
  parameter int unsigned CNT_W = $clog2(max4(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                             STABLE_CYCLES, CORE_RST_CYCLES))
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
  input  logic               clear_diag,
  output logic               pll_areset,
  output logic               sys_rst,
  output logic               ready,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost
);

  localparam logic [CNT_W-1:0]   PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CORE_LAST   = CNT_W'(CORE_RST_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = '1;

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pll_areset;
  logic               r_sys_rst;
  logic               r_ready;
  logic [RETRY_W-1:0] r_retry;
  logic               r_lock_lost;
  logic               w_lock_s;
  logic               w_inc_retry;
  logic               w_set_lost;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (nReset),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  // Lock loss is tested before completion/sw requests so it always wins.
  always_comb begin
    w_next      = r_state;
    w_inc_retry = 1'b0;
    w_set_lost  = 1'b0;
    case (r_state)
      PLL_RST:   if (r_cnt == PLL_LAST) w_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_next = STABLE;
        end else if (r_cnt == TO_LAST) begin
          w_next      = PLL_RST;
          w_inc_retry = 1'b1;
        end
      end
      STABLE: begin
        if (!w_lock_s)                w_next = WAIT_LOCK;
        else if (r_cnt == STABLE_LAST) w_next = CORE_RST;
      end
      CORE_RST: begin
        if (!w_lock_s)               w_next = PLL_RST;
        else if (r_cnt == CORE_LAST) w_next = RUN;
      end
      RUN: begin
        if (!w_lock_s) begin
          w_next     = PLL_RST;
          w_set_lost = 1'b1;
        end else if (sw_rst_req) begin
          w_next = CORE_RST;
        end
      end
      default:   w_next = PLL_RST;
    endcase
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state      <= PLL_RST;
      r_cnt        <= '0;
      r_pll_areset <= 1'b1;
      r_sys_rst    <= 1'b1;
      r_ready      <= 1'b0;
      r_retry      <= '0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_pll_areset <= (w_next == PLL_RST);
      r_sys_rst    <= (w_next != RUN);
      r_ready      <= (w_next == RUN);
      if (w_inc_retry) begin
        if (r_retry != RETRY_MAX) r_retry <= r_retry + 1'b1;
      end else if (clear_diag) begin
        r_retry <= '0;
      end
      if (w_set_lost)      r_lock_lost <= 1'b1;
      else if (clear_diag) r_lock_lost <= 1'b0;
    end
  end

  assign pll_areset = r_pll_areset;
  assign sys_rst    = r_sys_rst;
  assign ready      = r_ready;
  assign state      = r_state;
  assign retry_cnt  = r_retry;
  assign lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_rst_sequencer.sv
// Randomised bench for rst_sequencer against a phase/countdown reference model.
module tb_rst_sequencer;

  localparam int unsigned P_PLL = 4;
  localparam int unsigned P_TO  = 32;
  localparam int unsigned P_ST  = 8;
  localparam int unsigned P_CR  = 4;

  localparam int S_PLL  = 0;
  localparam int S_WAIT = 1;
  localparam int S_ST   = 2;
  localparam int S_CORE = 3;
  localparam int S_RUN  = 4;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       clear_diag = 1'b0;
  logic       pll_areset;
  logic       sys_rst;
  logic       ready;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic       lock_lost;

  int n_checks = 0;
  int n_pass   = 0;

  int m_phase;
  int m_left;
  int m_retry;
  bit m_lost;
  bit m_s1;
  bit m_s2;

  rst_sequencer #(
    .PLL_RST_CYCLES  (P_PLL),
    .LOCK_TIMEOUT    (P_TO),
    .STABLE_CYCLES   (P_ST),
    .CORE_RST_CYCLES (P_CR)
  ) dut (
    .clk        (clk),
    .nReset     (nReset),
    .pll_locked (pll_locked),
    .sw_rst_req (sw_rst_req),
    .clear_diag (clear_diag),
    .pll_areset (pll_areset),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .state      (state),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  function automatic int dwell(input int p);
    case (p)
      S_PLL:   return int'(P_PLL);
      S_WAIT:  return int'(P_TO);
      S_ST:    return int'(P_ST);
      S_CORE:  return int'(P_CR);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = S_PLL;
    m_left  = dwell(S_PLL);
    m_retry = 0;
    m_lost  = 1'b0;
    m_s1    = 1'b0;
    m_s2    = 1'b0;
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_left  = dwell(p);
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input bit lk, input bit sw, input bit clr);
    bit ls, inc, setl;
    if (!nReset) begin
      model_reset();
      return;
    end
    ls   = m_s2;
    inc  = 1'b0;
    setl = 1'b0;
    case (m_phase)
      S_PLL: begin
        m_left--;
        if (m_left == 0) enter(S_WAIT);
      end
      S_WAIT: begin
        if (ls) enter(S_ST);
        else begin
          m_left--;
          if (m_left == 0) begin enter(S_PLL); inc = 1'b1; end
        end
      end
      S_ST: begin
        if (!ls) enter(S_WAIT);
        else begin
          m_left--;
          if (m_left == 0) enter(S_CORE);
        end
      end
      S_CORE: begin
        if (!ls) enter(S_PLL);
        else begin
          m_left--;
          if (m_left == 0) enter(S_RUN);
        end
      end
      default: begin
        if (!ls) begin enter(S_PLL); setl = 1'b1; end
        else if (sw) enter(S_CORE);
      end
    endcase
    if (inc)      m_retry = (m_retry < 15) ? m_retry + 1 : 15;
    else if (clr) m_retry = 0;
    if (setl)     m_lost = 1'b1;
    else if (clr) m_lost = 1'b0;
    m_s2 = m_s1;
    m_s1 = lk;
  endtask

  task automatic check_outputs();
    chk("state",      int'(state),      m_phase);
    chk("pll_areset", int'(pll_areset), int'(m_phase == S_PLL));
    chk("sys_rst",    int'(sys_rst),    int'(m_phase != S_RUN));
    chk("ready",      int'(ready),      int'(m_phase == S_RUN));
    chk("retry_cnt",  int'(retry_cnt),  m_retry);
    chk("lock_lost",  int'(lock_lost),  int'(m_lost));
  endtask

  // Called at a falling edge: drive inputs, step model, check after the next rise.
  task automatic cycle(input bit lk, input bit sw, input bit clr);
    pll_locked = lk;
    sw_rst_req = sw;
    clear_diag = clr;
    model_step(lk, sw, clr);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    bit saw_pll;
    bit lvl;
    int len;

    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    nReset = 1'b1;

    // Clean bring-up, lock raised at edge 10.
    for (int c = 0; c < 40; c++) begin
      cycle(c >= 10, 1'b0, 1'b0);
      if (c == 2)  chk("bringup_areset_hi", int'(pll_areset), 1);
      if (c == 3)  chk("bringup_areset_lo", int'(pll_areset), 0);
      if (c == 11) chk("bringup_wait", int'(state), 1);
      if (c == 12) chk("bringup_stable", int'(state), 2);
      if (c == 23) chk("bringup_sysrst_hi", int'(sys_rst), 1);
      if (c == 24) begin
        chk("bringup_sysrst_lo", int'(sys_rst), 0);
        chk("bringup_ready", int'(ready), 1);
        chk("bringup_retry", int'(retry_cnt), 0);
      end
    end

    // Random software reset pulses while locked.
    for (int i = 0; i < 60; i++) cycle(1'b1, $urandom_range(0, 7) == 0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_phase == S_RUN) found = 1'b1;
      else cycle(1'b1, 1'b0, 1'b0);
    end
    chk("reach_run_sw", int'(found), 1);
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      chk("sw_sys_rst", int'(sys_rst), int'(k < 4));
      chk("sw_areset", int'(pll_areset), 0);
      cycle(1'b1, 1'b0, 1'b0);
    end

    // Lock loss in RUN, relock, then clear the sticky flag.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (i == 1) chk("loss_still_run", int'(state), 4);
      if (i == 2) begin
        chk("loss_state", int'(state), 0);
        chk("loss_flag", int'(lock_lost), 1);
      end
    end
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("relock_ready", int'(ready), 1);
    chk("relock_lost_kept", int'(lock_lost), 1);
    cycle(1'b1, 1'b0, 1'b1);
    chk("clear_lost", int'(lock_lost), 0);

    // sw request in the same cycle lock_s falls: lock loss wins.
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("same_cycle_state", int'(state), 0);
    chk("same_cycle_lost", int'(lock_lost), 1);

    // No lock: retries saturate.
    for (int i = 0; i < 600; i++) cycle(1'b0, $urandom_range(0, 9) == 0, 1'b0);
    chk("retry_sat", int'(retry_cnt), 15);
    chk("nolock_sysrst", int'(sys_rst), 1);

    // Glitchy lock from early WAIT_LOCK.
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (m_phase == S_WAIT && m_left > 20) found = 1'b1;
      else cycle(1'b0, 1'b0, 1'b0);
    end
    chk("reach_wait", int'(found), 1);
    saw_pll = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle(i != 5, 1'b0, 1'b0);
      if (state == 3'd0) saw_pll = 1'b1;
      if (i == 2) chk("glitch_stable", int'(state), 2);
      if (i == 7) chk("glitch_rewait", int'(state), 1);
      if (i == 8) chk("glitch_restable", int'(state), 2);
    end
    chk("glitch_no_pll", int'(saw_pll), 0);
    chk("glitch_run", int'(ready), 1);
    cycle(1'b1, 1'b0, 1'b1);
    chk("clear_retry", int'(retry_cnt), 0);

    // Random lock episodes with sporadic sw/clear requests.
    for (int e = 0; e < 30; e++) begin
      lvl = ($urandom_range(0, 1) == 1);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(8, 60));
      for (int i = 0; i < len; i++)
        cycle(lvl, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset during CORE_RST.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_phase == S_CORE) found = 1'b1;
      else cycle(1'b1, 1'b1, 1'b0);
    end
    chk("reach_core", int'(found), 1);
    #2 nReset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    cycle(1'b1, 1'b0, 1'b0);
    nReset = 1'b1;
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("restart_ready", int'(ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
